// File: rtl/cache_array_ctrl.sv
// Control FSM for a 2-way set-associative, write-back, write-allocate cache.
// Drives the tag/valid/dirty/LRU array loads, data-array enables and the line-level memory port.
module cache_array_ctrl #(
    parameter int s_offset = 5,
    parameter int s_index  = 3,
    parameter int s_tag    = 32 - s_offset - s_index
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [31:0]        mem_addr,
    output logic               mem_resp,
    output logic               pmem_read,
    output logic               pmem_write,
    output logic [31:0]        pmem_address,
    input  logic               pmem_resp,
    output logic [s_index-1:0] arr_index,
    input  logic [s_tag-1:0]   tag_out0,
    input  logic [s_tag-1:0]   tag_out1,
    input  logic               valid_out0,
    input  logic               valid_out1,
    input  logic               dirty_out0,
    input  logic               dirty_out1,
    input  logic               lru_out,
    output logic [1:0]         tag_valid_load,
    output logic [1:0]         dirty_load,
    output logic               dirty_in,
    output logic               lru_load,
    output logic               lru_in,
    output logic [1:0]         data_we,
    output logic               data_from_mem
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   r_victim;

    logic [s_tag-1:0] w_tag;
    logic [s_tag-1:0] w_victim_tag;
    logic             w_hit0;
    logic             w_hit1;
    logic             w_hit;
    logic             w_hit_way;
    logic             w_req;
    logic             w_wr;
    logic             w_lru_evict_dirty;
    logic             w_unused_offset;

    assign arr_index = mem_addr[s_offset +: s_index];
    assign w_tag     = mem_addr[31 -: s_tag];
    assign w_unused_offset = &{1'b0, mem_addr[s_offset-1:0]};

    assign w_hit0    = valid_out0 & (tag_out0 == w_tag);
    assign w_hit1    = valid_out1 & (tag_out1 == w_tag);
    assign w_hit     = w_hit0 | w_hit1;
    // A double hit is illegal; resolving it to way 0 keeps the enables one-hot.
    assign w_hit_way = w_hit1 & ~w_hit0;

    assign w_req = mem_read | mem_write;
    assign w_wr  = mem_write;

    assign w_victim_tag      = r_victim ? tag_out1 : tag_out0;
    assign w_lru_evict_dirty = lru_out ? (valid_out1 & dirty_out1) : (valid_out0 & dirty_out0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_victim <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_req && !w_hit) begin
                r_victim <= lru_out;
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = 32'd0;
        tag_valid_load = 2'b00;
        dirty_load     = 2'b00;
        dirty_in       = 1'b0;
        lru_load       = 1'b0;
        lru_in         = 1'b0;
        data_we        = 2'b00;
        data_from_mem  = 1'b0;

        // Reset masks every strobe so an interrupted refill or writeback leaves the arrays untouched.
        if (rst) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        if (w_hit) begin
                            mem_resp = 1'b1;
                            lru_load = 1'b1;
                            lru_in   = ~w_hit_way;
                            if (w_wr) begin
                                data_we[w_hit_way]    = 1'b1;
                                dirty_load[w_hit_way] = 1'b1;
                                dirty_in              = 1'b1;
                            end
                        end else begin
                            w_state_nxt = w_lru_evict_dirty ? WRITEBACK : FETCH;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write   = 1'b1;
                    pmem_address = {w_victim_tag, arr_index, {s_offset{1'b0}}};
                    if (pmem_resp) begin
                        dirty_load[r_victim] = 1'b1;
                        w_state_nxt          = FETCH;
                    end
                end
                FETCH: begin
                    pmem_read    = 1'b1;
                    pmem_address = {w_tag, arr_index, {s_offset{1'b0}}};
                    // The refilled line lands here; the following IDLE cycle hits and merges any write.
                    if (pmem_resp) begin
                        data_we[r_victim]        = 1'b1;
                        data_from_mem            = 1'b1;
                        tag_valid_load[r_victim] = 1'b1;
                        dirty_load[r_victim]     = 1'b1;
                        w_state_nxt              = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_array_ctrl.sv
// Scoreboard bench for cache_array_ctrl: behavioural cache-state model predicts memory
// transactions and completions per access; a negedge monitor pops and compares them.
module tb_cache_array_ctrl;

    localparam int OFF  = 5;
    localparam int IDX  = 3;
    localparam int TAGW = 32 - OFF - IDX;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_read;
    logic            mem_write;
    logic [31:0]     mem_addr;
    logic            mem_resp;
    logic            pmem_read;
    logic            pmem_write;
    logic [31:0]     pmem_address;
    logic            pmem_resp;
    logic [IDX-1:0]  arr_index;
    logic [TAGW-1:0] tag_out0, tag_out1;
    logic            valid_out0, valid_out1, dirty_out0, dirty_out1, lru_out;
    logic [1:0]      tag_valid_load, dirty_load, data_we;
    logic            dirty_in, lru_load, lru_in, data_from_mem;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_array_ctrl #(.s_offset(OFF), .s_index(IDX)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_resp(pmem_resp), .arr_index(arr_index),
        .tag_out0(tag_out0), .tag_out1(tag_out1), .valid_out0(valid_out0), .valid_out1(valid_out1),
        .dirty_out0(dirty_out0), .dirty_out1(dirty_out1), .lru_out(lru_out),
        .tag_valid_load(tag_valid_load), .dirty_load(dirty_load), .dirty_in(dirty_in),
        .lru_load(lru_load), .lru_in(lru_in), .data_we(data_we), .data_from_mem(data_from_mem)
    );

    // Array environment: registered arrays written from the DUT strobes, read combinationally.
    logic [TAGW-1:0] env_tag   [8][2];
    logic            env_valid [8][2];
    logic            env_dirty [8][2];
    logic            env_lru   [8];
    logic            env_clear;

    assign tag_out0   = env_tag[arr_index][0];
    assign tag_out1   = env_tag[arr_index][1];
    assign valid_out0 = env_valid[arr_index][0];
    assign valid_out1 = env_valid[arr_index][1];
    assign dirty_out0 = env_dirty[arr_index][0];
    assign dirty_out1 = env_dirty[arr_index][1];
    assign lru_out    = env_lru[arr_index];

    always @(posedge clk) begin
        if (env_clear) begin
            for (int s = 0; s < 8; s++) begin
                env_lru[s] <= 1'b0;
                for (int w = 0; w < 2; w++) begin
                    env_tag[s][w]   <= '0;
                    env_valid[s][w] <= 1'b0;
                    env_dirty[s][w] <= 1'b0;
                end
            end
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (tag_valid_load[w]) begin
                    env_tag[arr_index][w]   <= mem_addr[31 -: TAGW];
                    env_valid[arr_index][w] <= 1'b1;
                end
                if (dirty_load[w]) env_dirty[arr_index][w] <= dirty_in;
            end
            if (lru_load) env_lru[arr_index] <= lru_in;
        end
    end

    // Physical memory responder: fixed or random latency, plus a stray-pulse request.
    int fixed_lat = -1;
    int lat_cnt;
    bit busy;
    bit stray_req = 1'b0;
    bit stray_ack = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            pmem_resp <= 1'b0;
            busy      <= 1'b0;
            lat_cnt   <= 0;
        end else if (pmem_resp) begin
            pmem_resp <= 1'b0;
        end else if (stray_req != stray_ack) begin
            pmem_resp <= 1'b1;
            stray_ack <= stray_req;
        end else if (pmem_read || pmem_write) begin
            if (!busy) begin
                busy    <= 1'b1;
                lat_cnt <= (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 4));
            end else if (lat_cnt == 0) begin
                pmem_resp <= 1'b1;
                busy      <= 1'b0;
            end else begin
                lat_cnt <= lat_cnt - 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: cache contents by set/way, and the queue of expected DUT events.
    typedef struct {
        int          kind;   // 0 completion, 1 writeback, 2 refill
        logic [31:0] addr;
        bit          way;
        bit          wr;
    } ev_t;

    ev_t             q[$];
    logic [TAGW-1:0] ref_tag   [8][2];
    bit              ref_valid [8][2];
    bit              ref_dirty [8][2];
    bit              ref_lru   [8];

    task automatic predict(input logic [31:0] a, input bit wr);
        int              idx;
        int              w;
        logic [TAGW-1:0] t;
        ev_t             e;
        idx = int'(a[OFF +: IDX]);
        t   = a[31 -: TAGW];
        w   = -1;
        if (ref_valid[idx][0] && ref_tag[idx][0] == t) w = 0;
        else if (ref_valid[idx][1] && ref_tag[idx][1] == t) w = 1;
        if (w < 0) begin
            w = ref_lru[idx] ? 1 : 0;
            if (ref_valid[idx][w] && ref_dirty[idx][w]) begin
                e.kind = 1; e.addr = {ref_tag[idx][w], a[OFF +: IDX], 5'b0}; e.way = w[0]; e.wr = 1'b0;
                q.push_back(e);
                ref_dirty[idx][w] = 1'b0;
            end
            e.kind = 2; e.addr = {t, a[OFF +: IDX], 5'b0}; e.way = w[0]; e.wr = 1'b0;
            q.push_back(e);
            ref_tag[idx][w]   = t;
            ref_valid[idx][w] = 1'b1;
            ref_dirty[idx][w] = 1'b0;
        end
        e.kind = 0; e.addr = a; e.way = w[0]; e.wr = wr;
        q.push_back(e);
        ref_lru[idx] = (w == 0);
        if (wr) ref_dirty[idx][w] = 1'b1;
    endtask

    task automatic pop(output ev_t e, input string nm);
        chk({"expected_", nm}, (q.size() != 0), 1);
        if (q.size() != 0) e = q.pop_front();
        else begin e.kind = -1; e.addr = '0; e.way = 1'b0; e.wr = 1'b0; end
    endtask

    int last_hold = 0;

    // Monitor
    initial begin
        bit          prev_pr = 1'b0;
        bit          prev_pw = 1'b0;
        bit          fway = 1'b0;
        bit          wway = 1'b0;
        int          hold = 0;
        logic [31:0] hold_addr = '0;
        logic [1:0]  exp_we;
        ev_t         e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_pr = 1'b0;
                prev_pw = 1'b0;
                continue;
            end
            if (pmem_read && pmem_write) chk("pmem_exclusive", 32'd1, 32'd0);
            if (mem_resp) begin
                pop(e, "completion");
                chk("resp_kind", e.kind, 0);
                chk("resp_lru", {lru_load, lru_in}, {1'b1, ~e.way});
                exp_we = e.wr ? (2'b01 << e.way) : 2'b00;
                chk("resp_data_we", data_we, exp_we);
                chk("resp_dirty_load", dirty_load, exp_we);
                chk("resp_dirty_in", dirty_in, e.wr);
                chk("resp_misc", {data_from_mem, tag_valid_load, pmem_read, pmem_write}, 0);
            end else if (pmem_write) begin
                if (!prev_pw) begin
                    pop(e, "writeback");
                    chk("wb_kind", e.kind, 1);
                    chk("wb_addr", pmem_address, e.addr);
                    hold_addr = pmem_address;
                    wway = e.way;
                end else chk("wb_addr_stable", pmem_address, hold_addr);
                if (pmem_resp) begin
                    chk("wb_dirty_load", dirty_load, 2'b01 << wway);
                    chk("wb_dirty_in", dirty_in, 0);
                    chk("wb_other_loads", {tag_valid_load, data_we, lru_load}, 0);
                end else chk("wb_wait_loads", {tag_valid_load, dirty_load, data_we, lru_load}, 0);
            end else if (pmem_read) begin
                if (!prev_pr) begin
                    pop(e, "refill");
                    chk("fetch_kind", e.kind, 2);
                    chk("fetch_addr", pmem_address, e.addr);
                    hold_addr = pmem_address;
                    fway = e.way;
                    hold = 0;
                end else chk("fetch_addr_stable", pmem_address, hold_addr);
                if (pmem_resp) begin
                    last_hold = hold;
                    chk("fetch_tv_load", tag_valid_load, 2'b01 << fway);
                    chk("fetch_data_we", data_we, 2'b01 << fway);
                    chk("fetch_dirty_load", dirty_load, 2'b01 << fway);
                    chk("fetch_from_mem_din", {data_from_mem, dirty_in, lru_load}, 3'b100);
                end else begin
                    hold++;
                    chk("fetch_wait_loads", {tag_valid_load, dirty_load, data_we, lru_load}, 0);
                end
            end else begin
                chk("quiet_strobes", {tag_valid_load, dirty_load, data_we, lru_load, data_from_mem}, 0);
            end
            prev_pr = pmem_read;
            prev_pw = pmem_write;
        end
    end

    // Drive one access starting just after a rising edge; returns just after the edge that
    // ends the completion cycle, so a following call issues back-to-back.
    task automatic access(input logic [31:0] a, input bit wr, input bit rd);
        bit got;
        int n;
        predict(a, wr);
        mem_addr  = a;
        mem_write = wr;
        mem_read  = rd;
        n = 0;
        forever begin
            @(negedge clk);
            got = mem_resp;
            @(posedge clk);
            #1;
            if (got) break;
            n++;
            if (n > 300) begin
                chk("access_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        bit          wr;
        env_clear = 1'b1;
        rst       = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        for (int s = 0; s < 8; s++) begin
            ref_lru[s] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                ref_tag[s][w] = '0; ref_valid[s][w] = 1'b0; ref_dirty[s][w] = 1'b0;
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("reset_strobes", {mem_resp, pmem_read, pmem_write, tag_valid_load, dirty_load,
                                  dirty_in, lru_load, lru_in, data_we, data_from_mem}, 0);
            chk("reset_pmem_address", pmem_address, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        env_clear = 1'b0;

        // Cold read miss, then the hit completion after the refill.
        fixed_lat = 1;
        access(32'h0000_0040, 1'b0, 1'b1);
        idle();
        fixed_lat = -1;

        // Build set 3 so way 1 holds dirty tag 0xABC, then a miss evicts it.
        access(32'h0000_0160, 1'b0, 1'b1);
        access(32'h000A_BC60, 1'b1, 1'b0);
        access(32'h0000_0160, 1'b0, 1'b1);
        idle();
        access(32'h0000_0260, 1'b0, 1'b1);
        idle();

        // Write hit on way 1, then back-to-back read hits in two sets.
        access(32'h0000_0264, 1'b1, 1'b1);
        access(32'h0000_0040, 1'b0, 1'b1);
        access(32'h0000_0168, 1'b0, 1'b1);
        idle();

        // Long refill latency.
        fixed_lat = 12;
        access(32'h0000_0080, 1'b0, 1'b1);
        idle();
        chk("fetch_hold_ge10", (last_hold >= 10), 1);
        fixed_lat = -1;

        // Reset in the second FETCH cycle abandons the refill.
        begin
            ev_t e;
            e.kind = 2; e.addr = 32'h0000_00A0; e.way = ref_lru[5]; e.wr = 1'b0;
            q.push_back(e);
        end
        fixed_lat = 20;
        mem_addr = 32'h0000_00A0;
        mem_read = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_fetch_strobes", {pmem_read, pmem_write, tag_valid_load, dirty_load, lru_load,
                                  data_we, data_from_mem, mem_resp}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_read = 1'b0;
        @(negedge clk);
        chk("after_rst_pmem", {pmem_read, pmem_write}, 0);
        @(posedge clk); #1;
        stray_req = ~stray_req;
        repeat (4) @(posedge clk);
        #1;
        chk("stray_no_fill", {env_valid[5][0], env_valid[5][1]}, 0);
        chk("stray_queue_empty", q.size(), 0);
        fixed_lat = -1;

        // Randomized accesses over a small tag pool to force conflicts and evictions.
        for (int i = 0; i < 400; i++) begin
            a = {24'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
            wr = 1'($urandom_range(0, 1));
            access(a, wr, wr ? 1'($urandom_range(0, 1)) : 1'b1);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q.size(), 0);
        for (int s = 0; s < 8; s++) begin
            chk("final_lru", env_lru[s], ref_lru[s]);
            for (int w = 0; w < 2; w++) begin
                chk("final_valid", env_valid[s][w], ref_valid[s][w]);
                if (ref_valid[s][w]) begin
                    chk("final_tag", env_tag[s][w], ref_tag[s][w]);
                    chk("final_dirty", env_dirty[s][w], ref_dirty[s][w]);
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_array_ctrl.md
Name: cache_array_ctrl

Overview:
Control FSM for a 2-way set-associative, write-back, write-allocate cache. It drives the tag/valid/dirty/LRU register arrays and the data-array write enables, checks hits, and runs writeback and refill to physical memory.
- Arrays read combinationally and bypass a same-cycle load. The controller drives one set index, used as both rindex and windex.
- Sits between the CPU-side memory port and the cacheline adaptor.

Parameters:
s_offset, 5, byte-offset bits (32-byte line)
s_index, 3, set-index bits (8 sets)
s_tag, 32-s_offset-s_index, tag bits

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
mem_read  in  1  CPU read request, held until mem_resp
mem_write  in  1  CPU write request, held until mem_resp
mem_addr  in  32  CPU address, stable while request held
mem_resp  out  1  one-cycle completion pulse
pmem_read  out  1  line refill request
pmem_write  out  1  line writeback request
pmem_address  out  32  line address, offset bits zero
pmem_resp  in  1  one-cycle memory completion
arr_index  out  s_index  set index to all arrays = mem_addr[s_offset+:s_index]
tag_out0/tag_out1  in  s_tag  tag array read data per way
valid_out0/valid_out1  in  1  valid bits per way
dirty_out0/dirty_out1  in  1  dirty bits per way
lru_out  in  1  way to evict next
tag_valid_load  out  2  per-way load for tag+valid arrays (tag_in=mem_addr tag, valid_in=1)
dirty_load  out  2  per-way dirty load
dirty_in  out  1  dirty value written
lru_load  out  1  LRU array load
lru_in  out  1  new LRU value
data_we  out  2  per-way data-array line write enable
data_from_mem  out  1  1: data array takes refill line; 0: CPU write data with byte enables

Behaviour:
- Reset: state IDLE; all outputs 0 (mem_resp, pmem_*, loads, data_we, dirty_in, lru_in, data_from_mem); victim register 0.
- hitN = valid_outN & (tag_outN == mem_addr tag); hit = hit0|hit1; hit_way = hit1.
- Both ways hitting is illegal; if it occurs, way 0 wins.
- All outputs are combinational from state and inputs; only state and the victim register are flopped.
- IDLE, no request: all strobes 0.
- IDLE, request and hit, same cycle:
  - mem_resp=1; lru_load=1; lru_in=~hit_way.
  - On a write, also data_we[hit_way]=1, data_from_mem=0, dirty_load[hit_way]=1, dirty_in=1.
  - Stay in IDLE.
- IDLE, request and miss: latch victim=lru_out. Next state WRITEBACK if victim is valid & dirty, else FETCH. mem_resp=0.
- WRITEBACK:
  - pmem_write=1; pmem_address={victim tag, index, 0}, with the victim tag muxed from tag_out[victim].
  - Hold until pmem_resp. On pmem_resp: dirty_load[victim]=1, dirty_in=0; next state FETCH.
- FETCH:
  - pmem_read=1; pmem_address={mem_addr tag, index, 0}.
  - On pmem_resp, same cycle: data_we[victim]=1, data_from_mem=1, tag_valid_load[victim]=1, dirty_load[victim]=1, dirty_in=0; next state IDLE.
- After a refill, the first IDLE cycle hits and completes the request. A write gets merged there, so miss latency = memory latency + 1 cycle.
- pmem_read and pmem_write are never both 1. pmem_address stays stable while either is asserted.
- rst in any state, including mid-WRITEBACK or mid-FETCH: state becomes IDLE next edge. No array loads occur in the rst cycle, and the pending memory transaction is abandoned.
- A pmem_resp seen in IDLE is ignored.
- The requester drops or changes its request in the cycle after mem_resp. A request still held that cycle is treated as a new access.
- mem_read and mem_write both high is treated as a write.

Test Plan:
1. Reset, then read 0x00000040 (index 2, tag 0) with all valid=0 and lru_out=0:
   - next cycle pmem_read=1, pmem_address=0x00000040.
   - pmem_resp on cycle 3 → tag_valid_load=2'b01, data_we=2'b01, data_from_mem=1.
   - following cycle mem_resp=1, lru_in=1.
2. Write hit on way1 (valid_out1=1, tag_out1 matches):
   - same cycle mem_resp=1, data_we=2'b10, data_from_mem=0, dirty_load=2'b10, dirty_in=1, lru_in=0.
   - no pmem activity.
3. Read miss at index 3, lru_out=1, way1 valid+dirty with tag 0x000ABC:
   - pmem_write=1, pmem_address=0x000ABC60 until pmem_resp.
   - then dirty_load=2'b10 with dirty_in=0.
   - then pmem_read=1 with the new line address.
4. pmem_resp held low 10 cycles in FETCH → pmem_read=1 and pmem_address unchanged all 10 cycles; no array loads.
5. rst asserted on the 2nd cycle of FETCH → next cycle pmem_read=0, all loads 0. A later pmem_resp pulse causes no array writes.
6. Back-to-back read hits to different sets in consecutive cycles → mem_resp=1 both cycles; lru_load each cycle with lru_in = the way not hit.
